// File: rtl/ptp_pps_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : ptp_pps_gen_if
// Brief    : Time, width and target-time bundle for ptp_pps_gen.
// Revision : 1.0
// ============================================================================
interface ptp_pps_gen_if;
    logic [79:0] rtc_std_i;
    logic [31:0] pps_width_i;
    logic [47:0] tt_sec_i;
    logic [31:0] tt_ns_i;
    logic        tt_arm_i;
    logic        tt_cancel_i;
    logic        pps_o;
    logic        tt_trig_o;
    logic        tt_busy_o;
    logic        tt_late_o;

    modport master (
        output rtc_std_i, pps_width_i, tt_sec_i, tt_ns_i, tt_arm_i, tt_cancel_i,
        input  pps_o, tt_trig_o, tt_busy_o, tt_late_o
    );

    modport slave (
        input  rtc_std_i, pps_width_i, tt_sec_i, tt_ns_i, tt_arm_i, tt_cancel_i,
        output pps_o, tt_trig_o, tt_busy_o, tt_late_o
    );
endinterface
`default_nettype wire

// File: rtl/ptp_pps_gen.sv
`default_nettype none
// ============================================================================
// Module   : ptp_pps_gen
// Brief    : PPS pulse and target-time trigger generator on the RTC time base.
//            Define PTP_PPS_PERIODIC_EN to make the target re-arm every second.
// Revision : 1.0
// ============================================================================
module ptp_pps_gen (
    input  wire logic       rtc_clk,
    input  wire logic       rtc_rst,
    ptp_pps_gen_if.slave    bus
);

    localparam logic [31:0] c_ns_per_sec = 32'd1_000_000_000;
    localparam logic [31:0] c_max_width  = 32'd500_000_000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_FIRE  = 2'd2
    } state_t;

    state_t      r_state;
    logic [47:0] r_sec_d1;
    logic        r_primed;
    logic        r_pps;
    logic        r_trig;
    logic        r_busy;
    logic        r_late;
    logic        r_first;
    logic        r_width_nz;
    logic [47:0] r_t_sec;
    logic [31:0] r_t_ns;
    logic [47:0] r_e_sec;
    logic [31:0] r_e_ns;

    logic [47:0] w_sec;
    logic [31:0] w_ns;
    logic [31:0] w_width;
    logic        w_sec_inc;
    logic        w_ge_t;
    logic        w_ge_e;
    logic [31:0] w_e_ns_sum;
    logic        w_e_wrap;
    logic [31:0] w_e_ns;
    logic [47:0] w_e_sec;

    assign w_sec     = bus.rtc_std_i[79:32];
    assign w_ns      = bus.rtc_std_i[31:0];
    assign w_width   = (bus.pps_width_i > c_max_width) ? c_max_width : bus.pps_width_i;
    assign w_sec_inc = (w_sec == r_sec_d1 + 48'd1);
    assign w_ge_t    = (bus.rtc_std_i >= {r_t_sec, r_t_ns});
    assign w_ge_e    = (bus.rtc_std_i >= {r_e_sec, r_e_ns});

    // Both operands stay below 1e9 and 5e8, so the 32-bit sum cannot overflow.
    assign w_e_ns_sum = bus.tt_ns_i + w_width;
    assign w_e_wrap   = (w_e_ns_sum >= c_ns_per_sec);
    assign w_e_ns     = w_e_wrap ? (w_e_ns_sum - c_ns_per_sec) : w_e_ns_sum;
    assign w_e_sec    = w_e_wrap ? (bus.tt_sec_i + 48'd1) : bus.tt_sec_i;

    // r_primed blocks a bogus +1 between the reset value of r_sec_d1 and the first sample.
    always_ff @(posedge rtc_clk) begin
        if (rtc_rst) begin
            r_sec_d1 <= 48'd0;
            r_primed <= 1'b0;
            r_pps    <= 1'b0;
        end else begin
            r_sec_d1 <= w_sec;
            r_primed <= 1'b1;
            if (r_primed && w_sec_inc && (w_width != 32'd0)) begin
                r_pps <= 1'b1;
            end else if (w_sec != r_sec_d1) begin
                r_pps <= 1'b0;
            end else if (w_ns >= w_width) begin
                r_pps <= 1'b0;
            end
        end
    end

    always_ff @(posedge rtc_clk) begin
        if (rtc_rst) begin
            r_state    <= ST_IDLE;
            r_trig     <= 1'b0;
            r_busy     <= 1'b0;
            r_late     <= 1'b0;
            r_first    <= 1'b0;
            r_width_nz <= 1'b0;
            r_t_sec    <= 48'd0;
            r_t_ns     <= 32'd0;
            r_e_sec    <= 48'd0;
            r_e_ns     <= 32'd0;
        end else begin
            r_late <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.tt_arm_i && !bus.tt_cancel_i) begin
                        r_t_sec    <= bus.tt_sec_i;
                        r_t_ns     <= bus.tt_ns_i;
                        r_e_sec    <= w_e_sec;
                        r_e_ns     <= w_e_ns;
                        r_width_nz <= (w_width != 32'd0);
                        r_first    <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    r_first <= 1'b0;
                    if (bus.tt_cancel_i) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (w_ge_t) begin
                        if (r_first) begin
                            r_late  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_trig  <= r_width_nz;
                            r_state <= ST_FIRE;
                        end
                    end
                end
                ST_FIRE: begin
                    if (bus.tt_cancel_i || !w_ge_t) begin
                        r_trig  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (w_ge_e) begin
                        r_trig  <= 1'b0;
`ifdef PTP_PPS_PERIODIC_EN
                        r_t_sec <= r_t_sec + 48'd1;
                        r_e_sec <= r_e_sec + 48'd1;
                        r_state <= ST_ARMED;
`else
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
`endif
                    end
                end
                default: begin
                    r_trig  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.pps_o     = r_pps;
    assign bus.tt_trig_o = r_trig;
    assign bus.tt_busy_o = r_busy;
    assign bus.tt_late_o = r_late;

endmodule
`default_nettype wire

// File: tb/tb_ptp_pps_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_ptp_pps_gen
// Brief    : Directed self-checking bench for ptp_pps_gen.
// Revision : 1.0
// ============================================================================
module tb_ptp_pps_gen;

`ifdef PTP_PPS_PERIODIC_EN
    localparam logic c_periodic = 1'b1;
`else
    localparam logic c_periodic = 1'b0;
`endif

    logic rtc_clk = 1'b0;
    logic rtc_rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    ptp_pps_gen_if bus ();

    ptp_pps_gen dut (
        .rtc_clk (rtc_clk),
        .rtc_rst (rtc_rst),
        .bus     (bus)
    );

    always #5 rtc_clk = ~rtc_clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present a time sample, then return just after the edge that captured it.
    task automatic tick(input logic [47:0] sec, input logic [31:0] ns);
        bus.rtc_std_i = {sec, ns};
        @(posedge rtc_clk);
        #1;
    endtask

    task automatic arm(input logic [47:0] sec, input logic [31:0] ns);
        bus.tt_sec_i = sec;
        bus.tt_ns_i  = ns;
        bus.tt_arm_i = 1'b1;
    endtask

    initial begin
        bus.rtc_std_i   = 80'd0;
        bus.pps_width_i = 32'd100;
        bus.tt_sec_i    = 48'd0;
        bus.tt_ns_i     = 32'd0;
        bus.tt_arm_i    = 1'b0;
        bus.tt_cancel_i = 1'b0;

        tick(0, 0);
        tick(0, 0);
        check_val("rst_pps",  bus.pps_o, 0);
        check_val("rst_trig", bus.tt_trig_o, 0);
        check_val("rst_busy", bus.tt_busy_o, 0);
        check_val("rst_late", bus.tt_late_o, 0);
        rtc_rst = 1'b0;

        // PPS rollover 9 s -> 10 s, width 100 ns
        tick(1, 0);
        check_val("first_sample", bus.pps_o, 0);
        tick(9, 999_999_970);
        check_val("jump_no_pps", bus.pps_o, 0);
        tick(9, 999_999_980);
        tick(9, 999_999_990);
        check_val("pre_roll", bus.pps_o, 0);
        tick(10, 0);
        check_val("pps_rise", bus.pps_o, 1);
        for (int i = 1; i < 10; i++) begin
            tick(10, 32'(i * 10));
            check_val("pps_hold", bus.pps_o, 1);
        end
        tick(10, 100);
        check_val("pps_fall", bus.pps_o, 0);

        tick(5, 500);
        tick(20, 510);
        check_val("step_no_pps", bus.pps_o, 0);
        tick(0, 0);
        check_val("clear_no_pps", bus.pps_o, 0);

        // Width clamped to 500 ms
        bus.pps_width_i = 32'hFFFF_FFFF;
        tick(30, 999_999_990);
        tick(31, 0);
        check_val("clamp_rise", bus.pps_o, 1);
        tick(31, 499_999_990);
        check_val("clamp_hold", bus.pps_o, 1);
        tick(31, 500_000_000);
        check_val("clamp_fall", bus.pps_o, 0);

        bus.pps_width_i = 32'd0;
        tick(31, 999_999_990);
        tick(32, 0);
        check_val("w0_pps", bus.pps_o, 0);

        bus.pps_width_i = 32'd100;
        tick(32, 999_999_990);
        tick(33, 0);
        check_val("pps_rise2", bus.pps_o, 1);
        tick(40, 10);
        check_val("step_kill", bus.pps_o, 0);

        // Target 3 s 500 ns, width 200, armed at 2 s
        bus.pps_width_i = 32'd200;
        arm(3, 500);
        tick(2, 0);
        bus.tt_arm_i = 1'b0;
        check_val("arm_busy", bus.tt_busy_o, 1);
        tick(2, 10);
        check_val("arm_not_late", bus.tt_late_o, 0);
        arm(2, 100);
        tick(2, 20);
        bus.tt_arm_i = 1'b0;
        tick(2, 30);
        tick(3, 480);
        tick(3, 490);
        check_val("arm_ignored", bus.tt_trig_o, 0);
        tick(3, 500);
        check_val("tt_rise", bus.tt_trig_o, 1);
        check_val("tt_busy_fire", bus.tt_busy_o, 1);
        for (int n = 510; n < 700; n += 10) tick(3, 32'(n));
        check_val("tt_hold", bus.tt_trig_o, 1);
        tick(3, 700);
        check_val("tt_fall", bus.tt_trig_o, 0);
        check_val("tt_busy_after", bus.tt_busy_o, 32'(c_periodic));
        bus.tt_cancel_i = 1'b1;
        tick(3, 710);
        bus.tt_cancel_i = 1'b0;
        check_val("idle_after", bus.tt_busy_o, 0);

        // Late target
        arm(1, 0);
        tick(2, 0);
        bus.tt_arm_i = 1'b0;
        tick(2, 10);
        check_val("late_pulse", bus.tt_late_o, 1);
        check_val("late_busy", bus.tt_busy_o, 0);
        check_val("late_trig", bus.tt_trig_o, 0);
        tick(2, 20);
        check_val("late_once", bus.tt_late_o, 0);

        // Arm and cancel together
        arm(5, 0);
        bus.tt_cancel_i = 1'b1;
        tick(2, 30);
        bus.tt_arm_i    = 1'b0;
        bus.tt_cancel_i = 1'b0;
        check_val("arm_cancel", bus.tt_busy_o, 0);

        // Cancel during FIRE
        arm(2, 100);
        tick(2, 50);
        bus.tt_arm_i = 1'b0;
        tick(2, 60);
        tick(2, 100);
        check_val("fire2", bus.tt_trig_o, 1);
        bus.tt_cancel_i = 1'b1;
        tick(2, 110);
        bus.tt_cancel_i = 1'b0;
        check_val("cancel_fire", bus.tt_trig_o, 0);
        check_val("cancel_busy", bus.tt_busy_o, 0);

        // End time wraps into next second: E = 5 s 50 ns
        bus.pps_width_i = 32'd100;
        arm(4, 999_999_950);
        tick(4, 999_999_900);
        bus.tt_arm_i = 1'b0;
        tick(4, 999_999_910);
        tick(4, 999_999_950);
        check_val("wrap_rise", bus.tt_trig_o, 1);
        tick(5, 0);
        check_val("wrap_hold", bus.tt_trig_o, 1);
        tick(5, 40);
        check_val("wrap_hold2", bus.tt_trig_o, 1);
        tick(5, 50);
        check_val("wrap_fall", bus.tt_trig_o, 0);
        check_val("wrap_busy", bus.tt_busy_o, 32'(c_periodic));
`ifdef PTP_PPS_PERIODIC_EN
        tick(5, 999_999_940);
        check_val("periodic_wait", bus.tt_trig_o, 0);
        tick(5, 999_999_950);
        check_val("periodic_rise", bus.tt_trig_o, 1);
`endif
        bus.tt_cancel_i = 1'b1;
        tick(6, 0);
        bus.tt_cancel_i = 1'b0;

        // Zero width at arm: FSM walks through FIRE, trigger stays low
        bus.pps_width_i = 32'd0;
        arm(6, 20);
        tick(6, 0);
        bus.tt_arm_i = 1'b0;
        tick(6, 10);
        tick(6, 20);
        check_val("w0_trig", bus.tt_trig_o, 0);
        check_val("w0_fire_busy", bus.tt_busy_o, 1);
        tick(6, 30);
        check_val("w0_exit", bus.tt_busy_o, 32'(c_periodic));
        bus.tt_cancel_i = 1'b1;
        tick(6, 40);
        bus.tt_cancel_i = 1'b0;

        // Backward jump while firing
        bus.pps_width_i = 32'd100;
        arm(7, 0);
        tick(6, 999_999_990);
        bus.tt_arm_i = 1'b0;
        tick(6, 999_999_995);
        tick(7, 0);
        check_val("bwd_rise", bus.tt_trig_o, 1);
        tick(6, 500);
        check_val("bwd_trig", bus.tt_trig_o, 0);
        check_val("bwd_busy", bus.tt_busy_o, 0);

        // Reset while both pulses are high
        arm(8, 0);
        tick(7, 999_999_990);
        bus.tt_arm_i = 1'b0;
        tick(7, 999_999_995);
        tick(8, 0);
        check_val("pre_rst_pps", bus.pps_o, 1);
        check_val("pre_rst_trig", bus.tt_trig_o, 1);
        rtc_rst = 1'b1;
        tick(8, 10);
        check_val("mid_rst_pps", bus.pps_o, 0);
        check_val("mid_rst_trig", bus.tt_trig_o, 0);
        check_val("mid_rst_busy", bus.tt_busy_o, 0);
        rtc_rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ptp_pps_gen.md
PTP_PPS_GEN -- requirements
Module: ptp_pps_gen

Interface
REQ-001 SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 rtc_clk  in  1  RTC domain clock; all logic on rising edge.
REQ-003 rtc_rst  in  1  synchronous reset, active-high.
REQ-004 rtc_std_i  in  80  current time {sec[47:0], ns[31:0]} from RTC, ns in 0..999_999_999.
REQ-005 pps_width_i  in  32  pulse width, ns; shared by PPS and target-time outputs.
REQ-006 tt_sec_i  in  48  target time seconds.
REQ-007 tt_ns_i  in  32  target time nanoseconds, 0..999_999_999.
REQ-008 tt_arm_i  in  1  one-cycle pulse; latch target time and arm.
REQ-009 tt_cancel_i  in  1  one-cycle pulse; abort any armed or firing target.
REQ-010 pps_o  out  1  one-pulse-per-second output.
REQ-011 tt_trig_o  out  1  target-time trigger output, high for the pulse width.
REQ-012 tt_busy_o  out  1  high in ARMED or FIRE.
REQ-013 tt_late_o  out  1  one-cycle pulse: armed target was not in the future.

Function
REQ-014 Width rule: effective width W = min(pps_width_i, 500_000_000); W=0 SHALL suppress both pulses.
REQ-015 PPS: sample rtc_std_i each cycle into sec_d1; when sec == sec_d1+1 (exact +1 rollover) and W>0, pps_o SHALL go high on the next edge (latency 1 cycle).
REQ-016 pps_o SHALL stay high while ns < W and sec unchanged; deassert the cycle after ns >= W.
REQ-017 Any seconds change other than +1 (offset step, clear to 0, backward jump) SHALL produce no pulse and force pps_o low the next cycle.
REQ-018 Target FSM states: IDLE, ARMED, FIRE; tt_busy_o = (state != IDLE).
REQ-019 IDLE + tt_arm_i: latch T={tt_sec_i,tt_ns_i}; compute E = T+W, normalized (ns >= 1e9 -> ns-1e9, sec+1); go ARMED.
REQ-020 ARMED first cycle: if current time >= T (80-bit unsigned compare), pulse tt_late_o for one cycle and return to IDLE.
REQ-021 ARMED: when current >= T, go FIRE; tt_trig_o high on entering FIRE (1 cycle after the matching sample).
REQ-022 FIRE: when current >= E, tt_trig_o low and return to IDLE; if current < T (backward jump), same exit.
REQ-023 tt_arm_i in ARMED or FIRE SHALL be ignored.
REQ-024 tt_cancel_i SHALL return to IDLE next cycle with tt_trig_o low; cancel wins over simultaneous arm.
REQ-025 W=0 at arm: target still fires the FSM transition but tt_trig_o stays low.
REQ-026 All outputs registered; no combinational path input to output.

Reset
REQ-027 On rtc_rst: pps_o, tt_trig_o, tt_busy_o, tt_late_o = 0; state IDLE; T, E, sec_d1 = 0.
REQ-028 First sample after reset release SHALL only load sec_d1; no PPS on that cycle.
REQ-029 Reset mid-pulse SHALL drop all outputs on the same edge.

Configuration
REQ-030 Macro PTP_PPS_PERIODIC_EN: when defined, FIRE exit via E (not via cancel or backward jump) SHALL re-arm with T+=1 s, E+=1 s, state ARMED, tt_busy_o stays high; when undefined, target is single-shot and returns to IDLE.

Verification
REQ-031 Time 9 s 999_999_990 ns -> 10 s 0 ns, tick 10 ns, width 100 ns: pps_o high 1 cycle after 10 s sample, low after ns=100 sample.
REQ-032 Seconds step 5 -> 20 via offset, width 100: pps_o stays 0.
REQ-033 Arm T=3 s 500 ns, W=200 at time 2 s: tt_trig_o high after 3 s 500 ns sample, low after 3 s 700 ns sample; tt_busy_o 1 throughout.
REQ-034 Arm T=1 s 0 ns at time 2 s: tt_late_o one-cycle pulse, tt_busy_o back to 0, tt_trig_o never high.
REQ-035 Arm and cancel in same cycle -> stays IDLE; cancel during FIRE -> tt_trig_o low next cycle.
REQ-036 T=4 s 999_999_950 ns, W=100 -> E=5 s 50 ns; with PTP_PPS_PERIODIC_EN, second trigger at 5 s 999_999_950 ns.
